// File: rtl/reg_writeback_ctrl.sv
// Register-file writeback controller: arbitrates ALU/load results into a FIFO,
// drains one entry per cycle to the RF write port, and tracks pending writes.
// Optional: define WB_RR_ARB_EN for round-robin arbitration (default: mem-over-alu).
module reg_writeback_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [4:0]    alu_rd,
  input  logic [31:0]   alu_data,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  logic [4:0]    mem_rd,
  input  logic [31:0]   mem_data,
  input  logic          issue_valid,
  input  logic [4:0]    issue_rd,
  output logic          rf_we,
  output logic [4:0]    rf_rd,
  output logic [31:0]   rf_din,
  output logic [31:0]   busy,
  output logic [AW:0]   fifo_count
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;

  logic          rf_we_q, rf_we_d;
  logic [4:0]    rf_rd_q, rf_rd_d;
  logic [31:0]   rf_din_q, rf_din_d;
  logic [31:0]   busy_q, busy_d;

  logic          space;
  logic          alu_hs, mem_hs;
  logic          push, pop;
  logic [4:0]    push_rd;
  logic [31:0]   push_data;

  // Space is judged on the registered count only; a same-cycle pop does not help.
  assign space = (count_q < DEPTH_C);

`ifdef WB_RR_ARB_EN
  logic last_q, last_d;  // 1 = load unit granted last, 0 = ALU granted last

  always_comb begin
    mem_ready = space && (!alu_valid || !last_q);
    alu_ready = space && (!mem_valid || last_q);
  end

  always_comb begin
    last_d = last_q;
    if (mem_hs) begin
      last_d = 1'b1;
    end else if (alu_hs) begin
      last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end
`else
  always_comb begin
    mem_ready = space;
    alu_ready = space && !mem_valid;
  end
`endif

  assign mem_hs = mem_valid && mem_ready;
  assign alu_hs = alu_valid && alu_ready;

  always_comb begin
    push_rd   = alu_rd;
    push_data = alu_data;
    if (mem_hs) begin
      push_rd   = mem_rd;
      push_data = mem_data;
    end
  end

  // Writes to x0 complete the handshake but never occupy a slot.
  assign push = (mem_hs || alu_hs) && (push_rd != '0);
  assign pop  = (count_q != '0);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    rf_we_d  = 1'b0;
    rf_rd_d  = rf_rd_q;
    rf_din_d = rf_din_q;
    if (pop) begin
      rf_we_d  = 1'b1;
      rf_rd_d  = rd_mem_q[rptr_q];
      rf_din_d = data_mem_q[rptr_q];
    end
  end

  // Clear is applied before set so a same-edge issue to the same index survives.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= push_rd;
      data_mem_q[wptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rf_we_q  <= 1'b0;
      rf_rd_q  <= '0;
      rf_din_q <= '0;
      busy_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rf_we_q  <= rf_we_d;
      rf_rd_q  <= rf_rd_d;
      rf_din_q <= rf_din_d;
      busy_q   <= busy_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_din     = rf_din_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Randomized bench for reg_writeback_ctrl against a queue-based reference model.
module tb_reg_writeback_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, issue_valid;
  logic        alu_ready, mem_ready;
  logic [4:0]  alu_rd, mem_rd, issue_rd;
  logic [31:0] alu_data, mem_data;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_din;
  logic [31:0] busy;
  logic [AW:0] fifo_count;

  always #5 clk = ~clk;

  reg_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_din(rf_din), .busy(busy), .fifo_count(fifo_count)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  bit          m_we;
  bit [4:0]    m_rd;
  bit [31:0]   m_din;
  bit [31:0]   m_busy;
  bit          m_last_mem;
  bit          m_live;
  bit          last_ahs, last_mhs;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input bit iv, input logic [4:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    issue_valid = iv; issue_rd = ird;
  endtask

  task automatic idle();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0);
  endtask

  // One clock of model + comparison. Inputs are stable from posedge+1 to the next posedge.
  task automatic step();
    bit   space, ag, mg;
    ent_t e;
    @(negedge clk);
    space = (q.size() < DEPTH);
`ifdef WB_RR_ARB_EN
    mg = space && mem_valid && !(alu_valid && m_last_mem);
    ag = space && alu_valid && !(mem_valid && !m_last_mem);
`else
    mg = space && mem_valid;
    ag = space && alu_valid && !mem_valid;
`endif
    if (m_live) begin
      check("rf_we", rf_we, m_we);
      check("rf_rd", rf_rd, m_rd);
      check("rf_din", rf_din, m_din);
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, q.size());
      if (alu_valid) check("alu_ready", alu_ready, ag);
      if (mem_valid) check("mem_ready", mem_ready, mg);
    end
    last_ahs = ag;
    last_mhs = mg;
    if (rst) begin
      q.delete();
      m_we = 0; m_rd = 0; m_din = 0; m_busy = 0; m_last_mem = 0;
      m_live = 1;
    end else if (m_live) begin
      if (m_we) m_busy[m_rd] = 1'b0;
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (q.size() > 0) begin
        e = q.pop_front();
        m_we = 1; m_rd = e.rd; m_din = e.d;
      end else begin
        m_we = 0;
      end
      if (mg && mem_rd != 0) q.push_back({mem_rd, mem_data});
      else if (ag && alu_rd != 0) q.push_back({alu_rd, alu_data});
      if (mg) m_last_mem = 1;
      else if (ag) m_last_mem = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mi, ai;
    m_live = 0;
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;

    // Single ALU write: visible only after the edge following acceptance.
    drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0);
    step();
    check("alu_lat_early", rf_we, 1'b0);
    idle();
    step();
    check("alu_lat_we", rf_we, 1'b1);
    check("alu_lat_rd", rf_rd, 5'd5);
    check("alu_lat_din", rf_din, 32'hDEADBEEF);
    idle(); step();

    // Contention: load first, ALU one cycle later.
    drive(1, 5'd4, 32'h22, 1, 5'd3, 32'h11, 0, 5'd0);
    step();
    drive(1, 5'd4, 32'h22, 0, 5'd0, 32'd0, 0, 5'd0);
    step();
    check("cont_first", rf_rd, 5'd3);
    idle();
    step();
    check("cont_second", rf_rd, 5'd4);
    check("cont_second_din", rf_din, 32'h22);
    idle(); step();

    // Second contention held for two cycles; grant order comes from the model.
    drive(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB0, 0, 5'd0);
    step();
    if (last_ahs) alu_valid = 1'b0;
    if (last_mhs) mem_valid = 1'b0;
    step();
    idle(); step(); step();

    // x0 filter.
    drive(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, 0, 5'd0);
    step();
    check("x0_count", fifo_count, 0);
    idle(); step();
    check("x0_no_we", rf_we, 1'b0);

    // Scoreboard: set, clear by writeback, set-wins collision, x0 issue.
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    step();
    check("sb_set", busy[7], 1'b1);
    drive(1, 5'd7, 32'h77, 0, 5'd0, 32'd0, 0, 5'd0);
    step();
    idle(); step();
    step();
    check("sb_clear", busy[7], 1'b0);
    drive(1, 5'd7, 32'h78, 0, 5'd0, 32'd0, 1, 5'd7);
    step();
    idle(); step();
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd7);
    step();
    check("sb_set_wins", busy[7], 1'b1);
    drive(1, 5'd7, 32'h79, 0, 5'd0, 32'd0, 0, 5'd0);
    step();
    idle(); step(); step();
    check("sb_clear2", busy, 32'd0);
    drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0);
    step();
    check("sb_x0", busy, 32'd0);
    idle(); step();

    // Saturated producers: rd 1..8, load odd, ALU even; order checked by the model.
    mi = 0; ai = 0;
    for (int c = 0; c < 40 && (mi < 4 || ai < 4); c++) begin
      mem_valid = (mi < 4); mem_rd = 5'(1 + 2*mi); mem_data = 32'(100 + mi);
      alu_valid = (ai < 4); alu_rd = 5'(2 + 2*ai); alu_data = 32'(200 + ai);
      step();
      if (last_mhs) mi++;
      if (last_ahs) ai++;
    end
    check("sat_all_accepted", 32'(mi + ai), 32'd8);
    idle(); step(); step(); step();

    // Randomized traffic with stable-while-stalled producers and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if (!alu_valid || last_ahs) begin
        alu_valid = ($urandom_range(0, 99) < 60);
        alu_rd    = 5'($urandom_range(0, 31));
        alu_data  = $urandom;
      end
      if (!mem_valid || last_mhs) begin
        mem_valid = ($urandom_range(0, 99) < 50);
        mem_rd    = 5'($urandom_range(0, 31));
        mem_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 3) == 0);
      issue_rd    = 5'($urandom_range(0, 31));
      rst         = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    idle(); step(); step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
